mem_write_checker: RTL

- Synthesizable, parametrised self-checker for the processor's data-memory write port (memwrite/dataadr/writedata), instantiated beside single_cycle in benches and FPGA bring-up.
- Holds a programmable table of up to DEPTH expected (address, data) writes and checks the live write stream against it in order.
- Filters one configurable "don't-care" address, runs a cycle watchdog, and reports registered pass/fail status, counters and the first offending write.

---
 rtl/mem_write_checker_pkg.sv | 16 +
 rtl/mem_write_checker_cycle_watchdog.sv | 28 ++
 rtl/mem_write_checker.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker: FSM state encoding and index sizing.
package mem_write_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } mwc_state_e;

    // Width of a table index; a single-entry table still needs one bit
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_write_checker_cycle_watchdog.sv
// Run-length watchdog: counts enabled cycles and flags the cycle the count reaches TIMEOUT-1.
module cycle_watchdog #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Count parks at LAST so it can never wrap while still enabled
    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && cnt != LAST)
            cnt <= cnt + CW'(1);
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mem_write_checker.sv
// In-order checker of the processor store stream against a programmed table of expected writes.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 4,
    parameter int IGNORE_EN   = 1,
    parameter int IGNORE_ADDR = 80,
    parameter int TIMEOUT     = 1000,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       exp_we,
    input  logic [idx_w(DEPTH)-1:0]    exp_idx,
    input  logic [ADDR_W-1:0]          exp_addr,
    input  logic [DATA_W-1:0]          exp_data,
    input  logic [idx_w(DEPTH):0]      num_exp,
    input  logic                       start,
    input  logic                       memwrite,
    input  logic [ADDR_W-1:0]          dataadr,
    input  logic [DATA_W-1:0]          writedata,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [CNT_W-1:0]           mismatch_cnt,
    output logic [CNT_W-1:0]           ignore_cnt,
    output logic [ADDR_W-1:0]          fail_addr,
    output logic [DATA_W-1:0]          fail_data
);
    localparam int IW = idx_w(DEPTH);

    logic [ADDR_W+DATA_W-1:0] tbl [DEPTH];
    mwc_state_e               state, state_n;
    logic [IW-1:0]            ptr;
    logic [IW:0]              nexp, ptr_nx;
    logic                     is_ign, hit, last, wd_exp;
    logic                     do_ign, do_match, do_mis, do_to;

    assign is_ign = (IGNORE_EN != 0) && (dataadr == ADDR_W'(IGNORE_ADDR));
    assign hit    = (tbl[ptr] == {dataadr, writedata});
    assign ptr_nx = {1'b0, ptr} + (IW+1)'(1);
    assign last   = (ptr_nx == nexp);

    cycle_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .enable  (state == RUN && !start),
        .expired (wd_exp)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // start restarts from any state; the store on that edge is never checked
    always_comb begin
        state_n  = state;
        do_ign   = 1'b0;
        do_match = 1'b0;
        do_mis   = 1'b0;
        do_to    = 1'b0;
        if (start) begin
            state_n = RUN;
        end else if (state == RUN) begin
            if (nexp == '0) begin
                state_n = PASS;
            end else if (memwrite && is_ign) begin
                do_ign = 1'b1;
            end else if (memwrite) begin
                if (hit) begin
                    do_match = 1'b1;
                    if (last)
                        state_n = PASS;
                end else begin
                    do_mis  = 1'b1;
                    state_n = FAIL;
                end
            end
            // A terminal transition already taken on this edge beats the watchdog
            if (state_n == RUN && wd_exp) begin
                do_to   = 1'b1;
                state_n = FAIL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                tbl[i] <= '0;
            ptr          <= '0;
            nexp         <= '0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            ignore_cnt   <= '0;
            fail_addr    <= '0;
            fail_data    <= '0;
            timeout      <= 1'b0;
        end else begin
            if (state == IDLE && exp_we)
                tbl[exp_idx] <= {exp_addr, exp_data};
            if (start) begin
                ptr          <= '0;
                nexp         <= num_exp;
                match_cnt    <= '0;
                mismatch_cnt <= '0;
                ignore_cnt   <= '0;
                fail_addr    <= '0;
                fail_data    <= '0;
                timeout      <= 1'b0;
            end else begin
                if (do_ign && ignore_cnt != '1)
                    ignore_cnt <= ignore_cnt + CNT_W'(1);
                if (do_match) begin
                    if (match_cnt != '1)
                        match_cnt <= match_cnt + CNT_W'(1);
                    if (!last)
                        ptr <= ptr + IW'(1);
                end
                if (do_mis) begin
                    mismatch_cnt <= CNT_W'(1);
                    fail_addr    <= dataadr;
                    fail_data    <= writedata;
                end
                if (do_to)
                    timeout <= 1'b1;
            end
        end
    end

    assign busy = (state == RUN);
    assign pass = (state == PASS);
    assign fail = (state == FAIL);
    assign done = pass || fail;

endmodule
